// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control unit for the RV32 subset core.
// Sequences fetch/decode/execute/memory/write-back, handles memory
// wait-states with a bus-timeout watchdog, raises sticky traps and
// counts retired instructions.
module mc_ctrl_fsm #(
  parameter int unsigned         ALU_OP_W    = 4,
  parameter logic [ALU_OP_W-1:0] ALU_ADD     = 4'b0000,
  parameter logic [ALU_OP_W-1:0] ALU_SUB     = 4'b1000,
  parameter logic                MEM_WAIT_EN = 1'b1,
  parameter int unsigned         WAIT_MAX    = 16,
  parameter int unsigned         CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                is_r,
  input  logic                is_imm,
  input  logic                is_lui,
  input  logic                is_lw,
  input  logic                is_sw,
  input  logic                is_branch,
  input  logic                is_jalr,
  input  logic                is_jal,
  input  logic                illegal,
  input  logic [2:0]          funct3,
  input  logic [ALU_OP_W-1:0] alu_op_in,
  input  logic                zf,
  input  logic                sf,
  input  logic                cf,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc0_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem_write,
  output logic                mem_req,
  output logic                mdr_write,
  output logic                rs2_imm_s,
  output logic [1:0]          w_data_s,
  output logic [1:0]          pc_s,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    instret
);

  localparam logic [4:0] S_IDLE    = 5'd0;
  localparam logic [4:0] S_FETCH   = 5'd1;
  localparam logic [4:0] S_DECODE  = 5'd2;
  localparam logic [4:0] S_EX_R    = 5'd3;
  localparam logic [4:0] S_EX_I    = 5'd4;
  localparam logic [4:0] S_WB_ALU  = 5'd5;
  localparam logic [4:0] S_LUI     = 5'd6;
  localparam logic [4:0] S_JAL     = 5'd7;
  localparam logic [4:0] S_ADDR    = 5'd8;
  localparam logic [4:0] S_JALR    = 5'd9;
  localparam logic [4:0] S_LD_WAIT = 5'd10;
  localparam logic [4:0] S_LD_WB   = 5'd11;
  localparam logic [4:0] S_ST_WAIT = 5'd12;
  localparam logic [4:0] S_BR_CMP  = 5'd13;
  localparam logic [4:0] S_BR_DEC  = 5'd14;
  localparam logic [4:0] S_TRAP    = 5'd15;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_TMO = 2'b10;
  localparam logic [1:0] CAUSE_BR  = 2'b11;

  // Memory-class kind remembered from DECODE so ADDR can branch without
  // relying on the decoder flags staying valid.
  localparam logic [1:0] K_LW   = 2'b00;
  localparam logic [1:0] K_SW   = 2'b01;
  localparam logic [1:0] K_JALR = 2'b10;

  localparam int unsigned     WC_W    = $clog2(WAIT_MAX);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_MAX - 1);

  logic [4:0]          state_q,    state_d;
  logic [ALU_OP_W-1:0] alu_op_q,   alu_op_d;
  logic                rs2_imm_q,  rs2_imm_d;
  logic [1:0]          cause_q,    cause_d;
  logic [CNT_W-1:0]    instret_q,  instret_d;
  logic [WC_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [1:0]          kind_q,     kind_d;
  logic [2:0]          f3_q,       f3_d;
  logic                rdy_s;
  logic                wd_hit_s;
  logic                taken_s;
  logic                bad_f3_s;
  logic                retire_s;

  // With wait-states disabled the memory is treated as always ready,
  // which also keeps the watchdog from ever firing.
  assign rdy_s    = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign wd_hit_s = !rdy_s && (wait_cnt_q == WC_LAST);
  assign bad_f3_s = (f3_q[2:1] == 2'b01);

  assign alu_op_o   = alu_op_q;
  assign rs2_imm_s  = rs2_imm_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

  // Branch condition from the latched funct3 and the live ALU flags.
  always_comb begin
    taken_s = 1'b0;
    case (f3_q)
      3'b000:  taken_s = zf;
      3'b001:  taken_s = !zf;
      3'b100:  taken_s = sf;
      3'b101:  taken_s = !sf;
      3'b110:  taken_s = cf;
      3'b111:  taken_s = !cf;
      default: taken_s = 1'b0;
    endcase
  end

  // Next-state, registered-select, watchdog and retire decisions.
  always_comb begin
    state_d    = state_q;
    alu_op_d   = alu_op_q;
    rs2_imm_d  = rs2_imm_q;
    cause_d    = cause_q;
    kind_d     = kind_q;
    f3_d       = f3_q;
    wait_cnt_d = {WC_W{1'b0}};
    retire_s   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (rdy_s) begin
          state_d = S_DECODE;
        end else if (wd_hit_s) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TMO;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      S_DECODE: begin
        f3_d = funct3;
        if (illegal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILL;
        end else if (is_jal) begin
          state_d = S_JAL;
        end else if (is_lui) begin
          state_d = S_LUI;
        end else if (is_r) begin
          state_d = S_EX_R;
        end else if (is_imm) begin
          state_d = S_EX_I;
        end else if (is_lw) begin
          state_d = S_ADDR;
          kind_d  = K_LW;
        end else if (is_sw) begin
          state_d = S_ADDR;
          kind_d  = K_SW;
        end else if (is_jalr) begin
          state_d = S_ADDR;
          kind_d  = K_JALR;
        end else if (is_branch) begin
          state_d = S_BR_CMP;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILL;
        end
      end
      S_EX_R: begin
        alu_op_d  = alu_op_in;
        rs2_imm_d = 1'b0;
        state_d   = S_WB_ALU;
      end
      S_EX_I: begin
        alu_op_d  = alu_op_in;
        rs2_imm_d = 1'b1;
        state_d   = S_WB_ALU;
      end
      S_WB_ALU, S_LUI, S_JAL, S_JALR, S_LD_WB: begin
        retire_s = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDR: begin
        alu_op_d  = ALU_ADD;
        rs2_imm_d = 1'b1;
        case (kind_q)
          K_LW:    state_d = S_LD_WAIT;
          K_SW:    state_d = S_ST_WAIT;
          K_JALR:  state_d = S_JALR;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILL;
          end
        endcase
      end
      S_LD_WAIT, S_ST_WAIT: begin
        if (rdy_s) begin
          retire_s = (state_q == S_ST_WAIT);
          state_d  = (state_q == S_ST_WAIT) ? S_FETCH : S_LD_WB;
        end else if (wd_hit_s) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TMO;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      S_BR_CMP: begin
        alu_op_d  = ALU_SUB;
        rs2_imm_d = 1'b0;
        state_d   = S_BR_DEC;
      end
      S_BR_DEC: begin
        if (bad_f3_s) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BR;
        end else begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    instret_d = retire_s ? (instret_q + CNT_W'(1)) : instret_q;
  end

  // Datapath strobes and selects decoded from the current state.
  always_comb begin
    pc_write  = 1'b0;
    pc0_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    mem_req   = 1'b0;
    mdr_write = 1'b0;
    w_data_s  = 2'b00;
    pc_s      = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ir_write  = rdy_s;
        pc_write  = rdy_s;
        pc0_write = rdy_s;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_LUI: begin
        reg_write = 1'b1;
        w_data_s  = 2'b01;
      end
      S_JAL: begin
        reg_write = 1'b1;
        w_data_s  = 2'b11;
        pc_write  = 1'b1;
        pc_s      = 2'b01;
      end
      S_JALR: begin
        reg_write = 1'b1;
        w_data_s  = 2'b11;
        pc_write  = 1'b1;
        pc_s      = 2'b10;
      end
      S_LD_WAIT: begin
        mem_req   = 1'b1;
        mdr_write = rdy_s;
      end
      S_LD_WB: begin
        reg_write = 1'b1;
        w_data_s  = 2'b10;
      end
      S_ST_WAIT: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
      end
      S_BR_DEC: begin
        pc_write = taken_s && !bad_f3_s;
        pc_s     = 2'b01;
      end
      default: pc_s = 2'b00;
    endcase
  end

  // State and bookkeeping registers; reset returns to IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      alu_op_q   <= {ALU_OP_W{1'b0}};
      rs2_imm_q  <= 1'b0;
      cause_q    <= 2'b00;
      instret_q  <= {CNT_W{1'b0}};
      wait_cnt_q <= {WC_W{1'b0}};
      kind_q     <= 2'b00;
      f3_q       <= 3'b000;
    end else begin
      state_q    <= state_d;
      alu_op_q   <= alu_op_d;
      rs2_imm_q  <= rs2_imm_d;
      cause_q    <= cause_d;
      instret_q  <= instret_d;
      wait_cnt_q <= wait_cnt_d;
      kind_q     <= kind_d;
      f3_q       <= f3_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-cycle expected strobes, instret and trap
// state are queued as stimulus is driven and compared on the falling edge.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       is_r, is_imm, is_lui, is_lw, is_sw, is_branch, is_jalr, is_jal, illegal;
  logic [2:0] funct3;
  logic [3:0] alu_op_in;
  logic       zf, sf, cf, mem_ready;

  logic       pc_write, pc0_write, ir_write, reg_write, mem_write, mem_req, mdr_write, rs2_imm_s;
  logic [1:0] w_data_s, pc_s, trap_cause;
  logic [3:0] alu_op_o, instret;
  logic       trap;

  logic       pc_write_n, pc0_write_n, ir_write_n, reg_write_n, mem_write_n, mem_req_n, mdr_write_n, rs2_imm_s_n;
  logic [1:0] w_data_s_n, pc_s_n, trap_cause_n;
  logic [3:0] alu_op_o_n, instret_n;
  logic       trap_n;

  mc_ctrl_fsm #(.ALU_OP_W(4), .ALU_ADD(4'b0000), .ALU_SUB(4'b1000), .MEM_WAIT_EN(1'b1),
                .WAIT_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .is_r(is_r), .is_imm(is_imm), .is_lui(is_lui), .is_lw(is_lw),
    .is_sw(is_sw), .is_branch(is_branch), .is_jalr(is_jalr), .is_jal(is_jal), .illegal(illegal),
    .funct3(funct3), .alu_op_in(alu_op_in), .zf(zf), .sf(sf), .cf(cf), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc0_write(pc0_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_write(mem_write), .mem_req(mem_req), .mdr_write(mdr_write), .rs2_imm_s(rs2_imm_s),
    .w_data_s(w_data_s), .pc_s(pc_s), .alu_op_o(alu_op_o), .trap(trap),
    .trap_cause(trap_cause), .instret(instret));

  mc_ctrl_fsm #(.ALU_OP_W(4), .ALU_ADD(4'b0000), .ALU_SUB(4'b1000), .MEM_WAIT_EN(1'b0),
                .WAIT_MAX(4), .CNT_W(4)) dut_nw (
    .clk(clk), .rst_n(rst_n), .is_r(is_r), .is_imm(is_imm), .is_lui(is_lui), .is_lw(is_lw),
    .is_sw(is_sw), .is_branch(is_branch), .is_jalr(is_jalr), .is_jal(is_jal), .illegal(illegal),
    .funct3(funct3), .alu_op_in(alu_op_in), .zf(zf), .sf(sf), .cf(cf), .mem_ready(mem_ready),
    .pc_write(pc_write_n), .pc0_write(pc0_write_n), .ir_write(ir_write_n),
    .reg_write(reg_write_n), .mem_write(mem_write_n), .mem_req(mem_req_n),
    .mdr_write(mdr_write_n), .rs2_imm_s(rs2_imm_s_n), .w_data_s(w_data_s_n), .pc_s(pc_s_n),
    .alu_op_o(alu_op_o_n), .trap(trap_n), .trap_cause(trap_cause_n), .instret(instret_n));

  // Strobe word: {pc_write,pc0_write,ir_write,reg_write,mem_write,mem_req,mdr_write,w_data_s,pc_s}
  wire [10:0] strb_m = {pc_write, pc0_write, ir_write, reg_write, mem_write, mem_req, mdr_write, w_data_s, pc_s};
  wire [10:0] strb_n = {pc_write_n, pc0_write_n, ir_write_n, reg_write_n, mem_write_n, mem_req_n,
                        mdr_write_n, w_data_s_n, pc_s_n};

  localparam logic [10:0] Z      = 11'b0000000_0000;
  localparam logic [10:0] F_RDY  = 11'b1110010_0000;
  localparam logic [10:0] MREQ   = 11'b0000010_0000;
  localparam logic [10:0] WB_S   = 11'b0001000_0000;
  localparam logic [10:0] LUI_S  = 11'b0001000_0100;
  localparam logic [10:0] JAL_S  = 11'b1001000_1101;
  localparam logic [10:0] JALR_S = 11'b1001000_1110;
  localparam logic [10:0] LD_RDY = 11'b0000011_0000;
  localparam logic [10:0] LDWB_S = 11'b0001000_1000;
  localparam logic [10:0] ST_S   = 11'b0000110_0000;
  localparam logic [10:0] BR_T   = 11'b1000000_0001;
  localparam logic [10:0] BR_N   = 11'b0000000_0001;

  // Class word: {illegal,is_r,is_imm,is_lui,is_lw,is_sw,is_branch,is_jalr,is_jal}
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_ILL  = 9'b100000000;
  localparam logic [8:0] C_R    = 9'b010000000;
  localparam logic [8:0] C_IMM  = 9'b001000000;
  localparam logic [8:0] C_LUI  = 9'b000100000;
  localparam logic [8:0] C_LW   = 9'b000010000;
  localparam logic [8:0] C_SW   = 9'b000001000;
  localparam logic [8:0] C_BR   = 9'b000000100;
  localparam logic [8:0] C_JALR = 9'b000000010;
  localparam logic [8:0] C_JAL  = 9'b000000001;

  typedef struct {
    logic        nw;
    logic [10:0] strb;
    logic [3:0]  cnt;
    logic        trp;
    logic [1:0]  cause;
    logic        ca;
    logic [3:0]  alu;
    logic        rs2;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  cur_e;
  string cur_tag;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] nx_cls = 9'b0;
  logic [2:0] nx_f3  = 3'b000;
  logic [2:0] nx_fl  = 3'b000;
  logic [3:0] nx_alu = 4'b0000;
  logic       use_nw = 1'b0;
  logic [3:0] e_cnt  = 4'd0;
  logic       e_trap = 1'b0;
  logic [1:0] e_cause = 2'b00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show in it.
  task automatic step(input logic rdy, input logic [10:0] s, input logic ca,
                      input logic [3:0] alu, input logic rs2, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    mem_ready = rdy;
    {illegal, is_r, is_imm, is_lui, is_lw, is_sw, is_branch, is_jalr, is_jal} = nx_cls;
    funct3    = nx_f3;
    {zf, sf, cf} = nx_fl;
    alu_op_in = nx_alu;
    e.nw = use_nw; e.strb = s; e.cnt = e_cnt; e.trp = e_trap; e.cause = e_cause;
    e.ca = ca; e.alu = alu; e.rs2 = rs2;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic st(input logic rdy, input logic [10:0] s, input string tag);
    step(rdy, s, 1'b0, 4'b0000, 1'b0, tag);
  endtask

  // Scoreboard: pop one expectation per falling edge and compare.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur_e   = exp_q.pop_front();
      cur_tag = tag_q.pop_front();
      check_eq({cur_tag, "_strb"}, 32'(cur_e.nw ? strb_n : strb_m), 32'(cur_e.strb));
      check_eq({cur_tag, "_instret"}, 32'(cur_e.nw ? instret_n : instret), 32'(cur_e.cnt));
      check_eq({cur_tag, "_trap"}, {30'd0, (cur_e.nw ? trap_n : trap), 1'b0} >> 1, 32'(cur_e.trp));
      check_eq({cur_tag, "_cause"}, 32'(cur_e.nw ? trap_cause_n : trap_cause), 32'(cur_e.cause));
      if (cur_e.ca) begin
        check_eq({cur_tag, "_aluop"}, 32'(cur_e.nw ? alu_op_o_n : alu_op_o), 32'(cur_e.alu));
        check_eq({cur_tag, "_rs2imm"}, 32'(cur_e.nw ? rs2_imm_s_n : rs2_imm_s), 32'(cur_e.rs2));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    nx_cls = C_NONE; nx_f3 = 3'b000; nx_fl = 3'b000; nx_alu = 4'b0000;
    {illegal, is_r, is_imm, is_lui, is_lw, is_sw, is_branch, is_jalr, is_jal} = 9'b0;
    funct3 = 3'b000; {zf, sf, cf} = 3'b000; alu_op_in = 4'b0000; mem_ready = 1'b0;
    #2;
    check_eq("rst_strb", 32'(strb_m), 32'd0);
    check_eq("rst_strb_nw", 32'(strb_n), 32'd0);
    check_eq("rst_instret", 32'(instret), 32'd0);
    check_eq("rst_trap", 32'(trap), 32'd0);
    check_eq("rst_cause", 32'(trap_cause), 32'd0);
    check_eq("rst_aluop", 32'(alu_op_o), 32'd0);
    check_eq("rst_rs2imm", 32'(rs2_imm_s), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    e_cnt = 4'd0; e_trap = 1'b0; e_cause = 2'b00;
  endtask

  task automatic fetch_dec(input string t);
    st(1'b1, F_RDY, {t, "_fetch"});
    st(1'b1, Z, {t, "_decode"});
  endtask

  task automatic ins_lui(input string t);
    nx_cls = C_LUI;
    fetch_dec(t);
    st(1'b1, LUI_S, {t, "_lui"});
    e_cnt = e_cnt + 4'd1;
  endtask

  task automatic ins_alu(input logic [8:0] cls, input logic [3:0] op, input logic rs2, input string t);
    nx_cls = cls; nx_alu = op;
    fetch_dec(t);
    st(1'b1, Z, {t, "_ex"});
    step(1'b1, WB_S, 1'b1, op, rs2, {t, "_wb"});
    e_cnt = e_cnt + 4'd1;
  endtask

  task automatic ins_lw(input int waits, input string t);
    nx_cls = C_LW;
    fetch_dec(t);
    st(1'b1, Z, {t, "_addr"});
    for (int i = 0; i < waits; i++) step(1'b0, MREQ, 1'b1, 4'b0000, 1'b1, {t, "_wait"});
    step(1'b1, LD_RDY, 1'b1, 4'b0000, 1'b1, {t, "_ready"});
    st(1'b1, LDWB_S, {t, "_wb"});
    e_cnt = e_cnt + 4'd1;
  endtask

  task automatic ins_br(input logic [2:0] f3, input logic [2:0] fl, input logic taken, input string t);
    nx_cls = C_BR; nx_f3 = f3; nx_fl = fl;
    fetch_dec(t);
    st(1'b1, Z, {t, "_cmp"});
    step(1'b1, taken ? BR_T : BR_N, 1'b1, 4'b1000, 1'b0, {t, "_brdec"});
    e_cnt = e_cnt + 4'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b0;
    do_reset();

    // Basic instruction classes with zero wait-states.
    ins_alu(C_R, 4'b0110, 1'b0, "add");
    ins_alu(C_IMM, 4'b0011, 1'b1, "addi");
    ins_lw(3, "lw3");
    nx_cls = C_SW;
    fetch_dec("sw");
    st(1'b1, Z, "sw_addr");
    step(1'b1, ST_S, 1'b1, 4'b0000, 1'b1, "sw_st");
    e_cnt = e_cnt + 4'd1;
    nx_cls = C_JAL;
    fetch_dec("jal");
    st(1'b1, JAL_S, "jal_wb");
    e_cnt = e_cnt + 4'd1;
    ins_lui("lui");
    nx_cls = C_JALR;
    fetch_dec("jalr");
    st(1'b1, Z, "jalr_addr");
    step(1'b1, JALR_S, 1'b1, 4'b0000, 1'b1, "jalr_wb");
    e_cnt = e_cnt + 4'd1;

    // Branch conditions: flags are {zf,sf,cf}.
    ins_br(3'b001, 3'b000, 1'b1, "bne_t");
    ins_br(3'b111, 3'b001, 1'b0, "bgeu_n");
    ins_br(3'b000, 3'b100, 1'b1, "beq_t");
    ins_br(3'b100, 3'b010, 1'b1, "blt_t");
    ins_br(3'b101, 3'b010, 1'b0, "bge_n");
    ins_br(3'b110, 3'b000, 1'b0, "bltu_n");

    // Decode priority: jal beats lui, r beats imm.
    nx_cls = C_JAL | C_LUI;
    fetch_dec("prio_jal");
    st(1'b1, JAL_S, "prio_jal_wb");
    e_cnt = e_cnt + 4'd1;
    ins_alu(C_R | C_IMM, 4'b0101, 1'b0, "prio_r");

    // Ready arrives on the last allowed not-ready cycle boundary.
    nx_cls = C_LUI;
    for (int i = 0; i < 3; i++) st(1'b0, MREQ, "fw_wait");
    st(1'b1, F_RDY, "fw_ready");
    st(1'b1, Z, "fw_decode");
    st(1'b1, LUI_S, "fw_lui");
    e_cnt = e_cnt + 4'd1;

    // Asynchronous reset in the middle of a load wait.
    nx_cls = C_LW;
    fetch_dec("lwrst");
    st(1'b1, Z, "lwrst_addr");
    st(1'b0, MREQ, "lwrst_wait");
    do_reset();

    // Fetch bus timeout after four not-ready cycles.
    nx_cls = C_LUI;
    for (int i = 0; i < 4; i++) st(1'b0, MREQ, "tmo_wait");
    e_trap = 1'b1; e_cause = 2'b10;
    st(1'b1, Z, "tmo_trap_a");
    st(1'b0, Z, "tmo_trap_b");
    do_reset();

    // No class flags, then illegal with lui also set: cause 01.
    ins_lui("nof_pre");
    nx_cls = C_NONE;
    fetch_dec("nof");
    e_trap = 1'b1; e_cause = 2'b01;
    st(1'b1, Z, "nof_trap_a");
    st(1'b1, Z, "nof_trap_b");
    do_reset();
    nx_cls = C_ILL | C_LUI;
    fetch_dec("ill");
    e_trap = 1'b1; e_cause = 2'b01;
    st(1'b1, Z, "ill_trap");
    do_reset();

    // Reserved branch funct3 values: cause 11, no PC write, no retire.
    for (int k = 0; k < 2; k++) begin
      ins_lui("badbr_pre");
      nx_cls = C_BR; nx_f3 = (k == 0) ? 3'b010 : 3'b011; nx_fl = 3'b111;
      fetch_dec("badbr");
      st(1'b1, Z, "badbr_cmp");
      st(1'b1, BR_N, "badbr_dec");
      e_trap = 1'b1; e_cause = 2'b11;
      st(1'b1, Z, "badbr_trap_a");
      st(1'b0, Z, "badbr_trap_b");
      do_reset();
    end

    // Sixteen LUIs wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) ins_lui("wrap");
    st(1'b0, MREQ, "wrap_after");

    // Wait-states disabled: mem_ready=0 is ignored.
    use_nw = 1'b1;
    do_reset();
    nx_cls = C_LUI;
    st(1'b0, F_RDY, "nw_fetch");
    st(1'b0, Z, "nw_decode");
    st(1'b0, LUI_S, "nw_lui");
    e_cnt = e_cnt + 4'd1;
    nx_cls = C_LW;
    st(1'b0, F_RDY, "nwlw_fetch");
    st(1'b0, Z, "nwlw_decode");
    st(1'b0, Z, "nwlw_addr");
    step(1'b0, LD_RDY, 1'b1, 4'b0000, 1'b1, "nwlw_mem");
    st(1'b0, LDWB_S, "nwlw_wb");
    e_cnt = e_cnt + 4'd1;
    st(1'b0, F_RDY, "nw_next");

    @(negedge clk);
    #1;
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
